// File: rtl/spi_miso_rx.sv
// rtl/spi_miso_rx.sv - SPI MISO deserializer with little-endian frame assembly and valid/ack handoff
module spi_miso_rx #(
  parameter int FRAME_BYTES = 2,
  parameter bit SAMPLE_RISE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk,
  input  logic                     cs,
  input  logic                     receive,
  input  logic                     miso,
  input  logic                     sample_ack,
  output logic [7:0]               byte_data,
  output logic                     byte_valid,
  output logic [8*FRAME_BYTES-1:0] sample_data,
  output logic                     sample_valid,
  output logic                     overrun,
  output logic                     frame_abort
);
  localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic                     sclk_q;
  logic [6:0]               shift;
  logic [2:0]               bit_cnt;
  logic [IDX_W-1:0]         byte_idx;
  logic [8*FRAME_BYTES-1:0] frame_acc;
  logic [8*FRAME_BYTES-1:0] frame_nxt;
  logic [7:0]               byte_nxt;
  logic                     armed;
  logic                     sample_edge;
  logic                     shift_en;
  logic                     byte_done;
  logic                     frame_done;
  logic                     abort_nxt;

  assign armed       = ~cs & receive;
  assign sample_edge = SAMPLE_RISE ? (sclk & ~sclk_q) : (~sclk & sclk_q);
  assign byte_nxt    = {shift, miso};
  assign byte_done   = shift_en && (bit_cnt == 3'd7);
  assign frame_done  = byte_done && (byte_idx == LAST_IDX);

  // A change of arming takes priority over an edge in the same clk.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (armed) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (!armed) begin
          state_nxt = IDLE;
          abort_nxt = (bit_cnt != 3'd0) || (byte_idx != '0);
        end else begin
          shift_en = sample_edge;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_nxt = frame_acc;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (byte_idx == IDX_W'(i)) frame_nxt[8*i +: 8] = byte_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q       <= 1'b0;
      shift        <= '0;
      bit_cnt      <= '0;
      byte_idx     <= '0;
      frame_acc    <= '0;
      byte_data    <= '0;
      byte_valid   <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_abort  <= 1'b0;
    end else begin
      sclk_q      <= sclk;
      byte_valid  <= 1'b0;
      frame_abort <= abort_nxt;

      if (state == IDLE || !armed) begin
        shift    <= '0;
        bit_cnt  <= '0;
        byte_idx <= '0;
      end else if (shift_en) begin
        shift   <= byte_nxt[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          byte_data  <= byte_nxt;
          byte_valid <= 1'b1;
          frame_acc  <= frame_nxt;
          byte_idx   <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
        end
      end

      // An ack coinciding with a new frame retires the old sample only.
      if (frame_done) begin
        sample_data  <= frame_nxt;
        sample_valid <= 1'b1;
        if (sample_valid) overrun <= ~sample_ack;
      end else if (sample_valid && sample_ack) begin
        sample_valid <= 1'b0;
        overrun      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_miso_rx.sv
// tb/tb_spi_miso_rx.sv - randomized self-checking bench for spi_miso_rx
module tb_spi_miso_rx;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           sclk = 1'b0;
  logic           cs = 1'b1;
  logic           receive = 1'b0;
  logic           miso = 1'b0;
  logic           sample_ack = 1'b0;
  logic [7:0]     byte_data;
  logic           byte_valid;
  logic [8*N-1:0] sample_data;
  logic           sample_valid;
  logic           overrun;
  logic           frame_abort;

  int         checks = 0;
  int         failures = 0;
  int         bv_cnt = 0;
  int         fa_cnt = 0;
  logic [7:0] last_byte = 8'h00;

  always #5 clk = ~clk;

  spi_miso_rx #(.FRAME_BYTES(N), .SAMPLE_RISE(1'b1)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .receive(receive), .miso(miso),
    .sample_ack(sample_ack), .byte_data(byte_data), .byte_valid(byte_valid),
    .sample_data(sample_data), .sample_valid(sample_valid), .overrun(overrun),
    .frame_abort(frame_abort)
  );

  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt    = bv_cnt + 1;
      last_byte = byte_data;
    end
    if (frame_abort) fa_cnt = fa_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    miso = b;
    sclk = 1'b0;
    tick(2);
    sclk = 1'b1;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Final bit with optional ack in the clk its edge is captured; caller checks, then tick(1).
  task automatic send_last_bit(input logic b, input logic ack);
    miso = b;
    sclk = 1'b0;
    tick(2);
    sclk = 1'b1;
    sample_ack = ack;
    tick(1);
    sample_ack = 1'b0;
  endtask

  task automatic send_frame_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic ack);
    send_byte(b0);
    for (int i = 7; i >= 1; i--) send_bit(b1[i]);
    send_last_bit(b1[0], ack);
  endtask

  task automatic pulse_ack();
    sample_ack = 1'b1;
    tick(1);
    sample_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cs = 1'b1;
    receive = 1'b0;
    sclk = 1'b0;
    sample_ack = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic arm();
    cs = 1'b0;
    receive = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    logic [7:0] b;
    int bv0;
    rst = 1'b0;
    #2;
    checks++;
    if ({byte_data, byte_valid, sample_data, sample_valid, overrun, frame_abort} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got byte=%h sample=%h sv=%b ov=%b, want all 0", byte_data, sample_data, sample_valid, overrun);
    end
    tick(1);
    rst = 1'b1;
    bv0 = bv_cnt;
    tick(3);
    checks++;
    if (bv_cnt != bv0 || frame_abort !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_pulse: got %0d byte pulses abort=%b, want 0", bv_cnt - bv0, frame_abort);
    end
    arm();
    b = 8'($urandom_range(1, 255));
    send_byte(b);
    checks++;
    if (last_byte !== b) begin
      failures++;
      $display("FAIL reset_pre_byte: got %h want %h", last_byte, b);
    end
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({byte_data, byte_valid, sample_data, sample_valid, overrun, frame_abort} !== '0) begin
      failures++;
      $display("FAIL reset_mid_byte: got byte=%h sv=%b, want all 0", byte_data, sample_valid);
    end
    tick(1);
    rst = 1'b1;
    tick(2);
    bv0 = bv_cnt;
    send_byte(8'h5A);
    checks++;
    if (last_byte !== 8'h5A || bv_cnt - bv0 != 1) begin
      failures++;
      $display("FAIL reset_fresh_byte: got %h (%0d pulses) want 5a (1 pulse)", last_byte, bv_cnt - bv0);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    int bv0;
    do_reset();
    arm();
    b = 8'($urandom);
    bv0 = bv_cnt;
    send_byte(b);
    tick(2);
    checks++;
    if (bv_cnt - bv0 != 1 || byte_data !== b || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_byte: got %0d pulses byte=%h sv=%b, want 1 pulse %h sv=0", bv_cnt - bv0, byte_data, sample_valid, b);
    end
  endtask

  task automatic test_frame();
    do_reset();
    arm();
    send_frame_bytes(8'h34, 8'h12, 1'b0);
    checks++;
    if (byte_valid !== 1'b1 || sample_valid !== 1'b1 || sample_data !== 16'h1234) begin
      failures++;
      $display("FAIL frame_latency: got bv=%b sv=%b data=%h, want 1 1 1234", byte_valid, sample_valid, sample_data);
    end
    tick(1);
    checks++;
    if (byte_valid !== 1'b0) begin
      failures++;
      $display("FAIL byte_pulse_width: got bv=%b want 0", byte_valid);
    end
    tick(10);
    checks++;
    if (sample_valid !== 1'b1 || sample_data !== 16'h1234) begin
      failures++;
      $display("FAIL frame_hold: got sv=%b data=%h want 1 1234", sample_valid, sample_data);
    end
    pulse_ack();
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_ack: got sv=%b want 0", sample_valid);
    end
    pulse_ack();
    tick(1);
    checks++;
    if (sample_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack: got sv=%b ov=%b want 0 0", sample_valid, overrun);
    end
  endtask

  task automatic test_abort();
    int fa0;
    int bv0;
    do_reset();
    arm();
    fa0 = fa_cnt;
    bv0 = bv_cnt;
    repeat (5) send_bit(1'($urandom));
    cs = 1'b1;
    tick(3);
    checks++;
    if (fa_cnt - fa0 != 1 || bv_cnt != bv0) begin
      failures++;
      $display("FAIL abort_cs: got %0d aborts %0d bytes, want 1 0", fa_cnt - fa0, bv_cnt - bv0);
    end
    cs = 1'b0;
    tick(2);
    send_frame_bytes(8'h34, 8'h12, 1'b0);
    tick(1);
    checks++;
    if (sample_valid !== 1'b1 || sample_data !== 16'h1234) begin
      failures++;
      $display("FAIL abort_realign: got sv=%b data=%h want 1 1234", sample_valid, sample_data);
    end
    fa0 = fa_cnt;
    cs = 1'b1;
    tick(3);
    checks++;
    if (fa_cnt != fa0) begin
      failures++;
      $display("FAIL clean_disarm: got %0d aborts want 0", fa_cnt - fa0);
    end
    cs = 1'b0;
    tick(2);
    send_byte(8'($urandom));
    fa0 = fa_cnt;
    receive = 1'b0;
    tick(3);
    checks++;
    if (fa_cnt - fa0 != 1) begin
      failures++;
      $display("FAIL abort_receive_partial_frame: got %0d aborts want 1", fa_cnt - fa0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] a0, a1, b0, b1;
    logic [8*N-1:0] exp_b;
    do_reset();
    arm();
    a0 = 8'($urandom); a1 = 8'($urandom);
    b0 = 8'($urandom); b1 = 8'($urandom);
    exp_b = 16'(b0 + 256 * b1);
    send_frame_bytes(a0, a1, 1'b0);
    tick(1);
    send_frame_bytes(b0, b1, 1'b0);
    tick(1);
    checks++;
    if (sample_data !== exp_b || sample_valid !== 1'b1 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun: got data=%h sv=%b ov=%b want %h 1 1", sample_data, sample_valid, overrun, exp_b);
    end
    pulse_ack();
    checks++;
    if (sample_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: got sv=%b ov=%b want 0 0", sample_valid, overrun);
    end
  endtask

  task automatic test_simultaneous_ack();
    logic [7:0] b0, b1;
    logic [8*N-1:0] exp_b;
    do_reset();
    arm();
    send_frame_bytes(8'($urandom), 8'($urandom), 1'b0);
    tick(1);
    b0 = 8'($urandom); b1 = 8'($urandom);
    exp_b = 16'(b0 + 256 * b1);
    send_frame_bytes(b0, b1, 1'b1);
    checks++;
    if (sample_data !== exp_b || sample_valid !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL simul_ack: got data=%h sv=%b ov=%b want %h 1 0", sample_data, sample_valid, overrun, exp_b);
    end
    tick(1);
    pulse_ack();
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_ack_followup: got sv=%b want 0", sample_valid);
    end
  endtask

  task automatic test_gating();
    int fa0;
    int bv0;
    logic [7:0] b;
    do_reset();
    for (int mode = 0; mode < 2; mode++) begin
      cs = (mode == 1);
      receive = (mode == 1);
      tick(2);
      fa0 = fa_cnt;
      bv0 = bv_cnt;
      repeat (16) begin
        miso = 1'($urandom);
        sclk = ~sclk;
        tick(2);
      end
      checks++;
      if (bv_cnt != bv0 || fa_cnt != fa0 ||
          {byte_data, sample_data, sample_valid, overrun} !== '0) begin
        failures++;
        $display("FAIL gating_mode%0d: got %0d bytes %0d aborts byte=%h sv=%b, want none", mode, bv_cnt - bv0, fa_cnt - fa0, byte_data, sample_valid);
      end
    end
    arm();
    b = 8'($urandom);
    send_byte(b);
    checks++;
    if (last_byte !== b) begin
      failures++;
      $display("FAIL gating_then_byte: got %h want %h", last_byte, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]     b0, b1;
    logic [8*N-1:0] exp_sample;
    logic           exp_valid;
    logic           exp_overrun;
    logic           ack;
    exp_sample = '0;
    exp_valid = 1'b0;
    exp_overrun = 1'b0;
    do_reset();
    arm();
    for (int f = 0; f < 8; f++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      ack = ($urandom_range(0, 3) == 0);
      send_frame_bytes(b0, b1, ack);
      if (exp_valid) exp_overrun = !ack;
      exp_valid = 1'b1;
      exp_sample = 16'(b0 + 256 * b1);
      checks++;
      if (sample_data !== exp_sample || sample_valid !== exp_valid ||
          overrun !== exp_overrun || byte_data !== b1) begin
        failures++;
        $display("FAIL b2b_frame%0d: got data=%h sv=%b ov=%b byte=%h want %h %b %b %h", f, sample_data, sample_valid, overrun, byte_data, exp_sample, exp_valid, exp_overrun, b1);
      end
      tick(1);
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        exp_valid = 1'b0;
        exp_overrun = 1'b0;
        checks++;
        if (sample_valid !== exp_valid || overrun !== exp_overrun) begin
          failures++;
          $display("FAIL b2b_ack%0d: got sv=%b ov=%b want 0 0", f, sample_valid, overrun);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_frame();
    test_abort();
    test_overrun();
    test_simultaneous_ack();
    test_gating();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
